// File: rtl/l2_pmem_responder_if.sv
// pmem line-transfer bus between the L2 controller (master) and main memory (slave).
interface l2_pmem_responder_if #(
    parameter int LINE_BITS  = 128,
    parameter int ADDR_WIDTH = 16
);
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_BITS-1:0]  pmem_wdata;
    logic [LINE_BITS-1:0]  pmem_rdata;
    logic                  pmem_resp;
    logic                  protocol_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, protocol_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, protocol_err
    );
endinterface

// File: rtl/l2_pmem_responder.sv
// Line-granular main-memory responder: one request at a time, fixed per-op latency,
// single-cycle pmem_resp pulse, sticky protocol_err on malformed or dropped requests.
module l2_pmem_responder #(
    parameter int LINE_BITS     = 128,
    parameter int ADDR_WIDTH    = 16,
    parameter int OFFSET_BITS   = 4,
    parameter int INDEX_BITS    = 8,
    parameter int READ_LATENCY  = 10,
    parameter int WRITE_LATENCY = 10
) (
    input  logic                clk,
    input  logic                reset,
    l2_pmem_responder_if.slave  bus
);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int DEPTH   = 2 ** INDEX_BITS;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [LINE_BITS-1:0]    wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [LINE_BITS-1:0]    rdata_q;
    logic                    rd_load;
    logic [INDEX_BITS-1:0]   rd_idx;
    logic [INDEX_BITS-1:0]   req_idx;
    logic                    still_valid;
    logic                    unused_addr;

    logic [LINE_BITS-1:0]    mem [DEPTH];

    assign req_idx     = bus.pmem_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign unused_addr = ^bus.pmem_address;
    // An op switch mid-transaction counts as a drop, even if the other request line stays high.
    assign still_valid = op_wr_q ? (bus.pmem_write & ~bus.pmem_read)
                                 : (bus.pmem_read & ~bus.pmem_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rd_load = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.pmem_read ^ bus.pmem_write) begin
                    op_wr_d = bus.pmem_write;
                    idx_d   = req_idx;
                    wdata_d = bus.pmem_wdata;
                    cnt_d   = bus.pmem_write ? WR_LOAD : RD_LOAD;
                    if (cnt_d == '0) begin
                        state_d = RESPOND;
                        rd_load = bus.pmem_read;
                        rd_idx  = req_idx;
                    end else begin
                        state_d = BUSY;
                    end
                end else if (bus.pmem_read && bus.pmem_write) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (!still_valid) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = RESPOND;
                        rd_load = ~op_wr_q;
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Synchronous read port: rdata is captured on entry to RESPOND and held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            rdata_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == RESPOND && op_wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.pmem_rdata   = rdata_q;
    assign bus.pmem_resp    = (state_q == RESPOND);
    assign bus.protocol_err = err_q;
endmodule
